// File: rtl/smvm_kstream.sv
// smvm_kstream: K-lane streaming sparse-matrix x dense-vector engine.
// A CFG beat sets the column count, VEC beats load the dense vector, and MAT
// beats carry up to K nonzeros (value, column, end-of-row). Stage S1 forms the
// lane products; stage S2 is a segmented reduction that pushes finished rows
// into a first-word-fall-through output FIFO with ready/valid backpressure.
// Optional feature macro: SMVM_SAT_EN (saturating accumulation + out_sat).
module smvm_kstream #(
    parameter int K          = 4,
    parameter int VAL_W      = 8,
    parameter int IDX_W      = 9,
    parameter int ACC_W      = 24,
    parameter int ROW_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K-1:0]         in_lane_vld,
    input  logic [K*VAL_W-1:0]   in_val,
    input  logic [K*IDX_W-1:0]   in_idx,
    input  logic [K-1:0]         in_eor,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [ROW_W-1:0]     out_row,
    output logic                 out_sat,
    output logic                 err_oob,
    output logic                 busy
);
    // Handshakes: a beat transfers on a rising clk edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready, and the output fields hold
    // stable while out_valid is high and out_ready is low.

    localparam int COL_W = IDX_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PC_W  = $clog2(K + 1);
    localparam int SL_W  = $clog2(K);

    typedef enum logic [1:0] {IDLE, VEC, MAT, FLUSH} state_t;

    state_t             state;
    logic [COL_W-1:0]   cols;
    logic [COL_W-1:0]   vec_base;
    logic [VAL_W-1:0]   vec_mem [2**IDX_W];

    logic accept, cfg_accept, vec_accept, mat_accept;

    // S1 registers
    logic               s1_valid;
    logic [ACC_W-1:0]   s1_prod [K];
    logic [K-1:0]       s1_lv, s1_eor;
    logic               s1_last;

    // S2 state and next-state values
    logic [ACC_W-1:0]   acc, acc_w;
    logic               row_open, open_w;
    logic [ROW_W-1:0]   row_cnt, row_w;
    logic [K-1:0]       push_vld;
    logic [ACC_W-1:0]   push_data [K];
    logic [ROW_W-1:0]   push_row [K];
    logic [PC_W-1:0]    push_cnt;
`ifdef SMVM_SAT_EN
    logic               row_sat, sat_w;
    logic [K-1:0]       push_sat;
    logic [ACC_W:0]     sum;
    logic               fifo_sat [FIFO_DEPTH];
`endif

    // Output FIFO
    logic [ACC_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [ROW_W-1:0]   fifo_row  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_count, free_slots;
    logic               pop;

    logic [ACC_W-1:0]   prod_c [K];
    logic [K-1:0]       oob_c;

    assign accept     = in_valid && in_ready;
    assign cfg_accept = accept && (state == IDLE);
    assign vec_accept = accept && (state == VEC);
    assign mat_accept = accept && (state == MAT);
    assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign pop        = out_valid && out_ready;

    function automatic logic [2*VAL_W-1:0] mul(input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
        return (2*VAL_W)'(a) * (2*VAL_W)'(b);
    endfunction

    // Input acceptance: MAT holds off unless two full beats of pushes fit in the FIFO
    always_comb begin
        case (state)
            IDLE, VEC: in_ready = 1'b1;
            MAT:       in_ready = (free_slots >= CNT_W'(2*K));
            default:   in_ready = 1'b0;
        endcase
    end

    // Phase sequencer: CFG -> vector load -> matrix stream -> drain pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cols     <= '0;
            vec_base <= '0;
            err_oob  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cols     <= {1'b0, in_idx[IDX_W-1:0]} + COL_W'(1);
                    vec_base <= '0;
                    err_oob  <= 1'b0;
                    state    <= VEC;
                end
                VEC: if (accept) begin
                    if (({1'b0, vec_base} + (COL_W+1)'(K)) >= {1'b0, cols})
                        state <= MAT;
                    vec_base <= vec_base + COL_W'(K);
                end
                MAT: if (accept) begin
                    if (|oob_c) err_oob <= 1'b1;
                    if (in_last) state <= FLUSH;
                end
                FLUSH: if (!s1_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Vector RAM write during VEC beats; lanes past the last column are ignored
    always_ff @(posedge clk) begin
        if (vec_accept) begin
            for (int j = 0; j < K; j++) begin
                if ((vec_base + COL_W'(j)) < cols)
                    vec_mem[IDX_W'(vec_base + COL_W'(j))] <= in_val[j*VAL_W +: VAL_W];
            end
        end
    end

    // Lane products; out-of-range or invalid lanes produce zero
    always_comb begin
        for (int j = 0; j < K; j++) begin
            prod_c[j] = '0;
            oob_c[j]  = 1'b0;
            if (in_lane_vld[j]) begin
                if ({1'b0, in_idx[j*IDX_W +: IDX_W]} < cols)
                    prod_c[j] = ACC_W'(mul(in_val[j*VAL_W +: VAL_W], vec_mem[in_idx[j*IDX_W +: IDX_W]]));
                else
                    oob_c[j] = 1'b1;
            end
        end
    end

    // S1 pipeline register, loaded on every accepted MAT beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lv    <= '0;
            s1_eor   <= '0;
            s1_last  <= 1'b0;
            for (int j = 0; j < K; j++) s1_prod[j] <= '0;
        end else begin
            s1_valid <= mat_accept;
            if (mat_accept) begin
                s1_lv   <= in_lane_vld;
                s1_eor  <= in_eor;
                s1_last <= in_last;
                for (int j = 0; j < K; j++) s1_prod[j] <= prod_c[j];
            end
        end
    end

    // Segmented reduction: walk lanes in order, emit a row on each EOR and on last
    always_comb begin
        acc_w    = acc;
        open_w   = row_open;
        row_w    = row_cnt;
        push_vld = '0;
        push_cnt = '0;
        for (int n = 0; n < K; n++) begin
            push_data[n] = '0;
            push_row[n]  = '0;
        end
`ifdef SMVM_SAT_EN
        sat_w    = row_sat;
        push_sat = '0;
        sum      = '0;
`endif
        if (s1_valid) begin
            for (int j = 0; j < K; j++) begin
                if (s1_lv[j]) begin
`ifdef SMVM_SAT_EN
                    sum = {1'b0, acc_w} + {1'b0, s1_prod[j]};
                    if (sum[ACC_W]) begin
                        acc_w = '1;
                        sat_w = 1'b1;
                    end else begin
                        acc_w = sum[ACC_W-1:0];
                    end
`else
                    acc_w = acc_w + s1_prod[j];
`endif
                    open_w = 1'b1;
                    if (s1_eor[j]) begin
                        push_vld[push_cnt[SL_W-1:0]]  = 1'b1;
                        push_data[push_cnt[SL_W-1:0]] = acc_w;
                        push_row[push_cnt[SL_W-1:0]]  = row_w;
`ifdef SMVM_SAT_EN
                        push_sat[push_cnt[SL_W-1:0]]  = sat_w;
                        sat_w = 1'b0;
`endif
                        push_cnt = push_cnt + PC_W'(1);
                        row_w    = row_w + ROW_W'(1);
                        acc_w    = '0;
                        open_w   = 1'b0;
                    end
                end
            end
            // An open row can only remain if lane K-1 did not close one, so a slot is free
            if (s1_last && open_w) begin
                push_vld[push_cnt[SL_W-1:0]]  = 1'b1;
                push_data[push_cnt[SL_W-1:0]] = acc_w;
                push_row[push_cnt[SL_W-1:0]]  = row_w;
`ifdef SMVM_SAT_EN
                push_sat[push_cnt[SL_W-1:0]]  = sat_w;
                sat_w = 1'b0;
`endif
                push_cnt = push_cnt + PC_W'(1);
                row_w    = row_w + ROW_W'(1);
                acc_w    = '0;
                open_w   = 1'b0;
            end
        end
    end

    // Reduction state: restarts on CFG, advances whenever S1 holds a beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            row_open <= 1'b0;
            row_cnt  <= '0;
`ifdef SMVM_SAT_EN
            row_sat  <= 1'b0;
`endif
        end else if (cfg_accept) begin
            acc      <= '0;
            row_open <= 1'b0;
            row_cnt  <= '0;
`ifdef SMVM_SAT_EN
            row_sat  <= 1'b0;
`endif
        end else if (s1_valid) begin
            acc      <= acc_w;
            row_open <= open_w;
            row_cnt  <= row_w;
`ifdef SMVM_SAT_EN
            row_sat  <= sat_w;
`endif
        end
    end

    // FIFO storage: up to K consecutive slots written per cycle
    always_ff @(posedge clk) begin
        for (int n = 0; n < K; n++) begin
            if (push_vld[n]) begin
                fifo_data[wr_ptr + PTR_W'(n)] <= push_data[n];
                fifo_row[wr_ptr + PTR_W'(n)]  <= push_row[n];
`ifdef SMVM_SAT_EN
                fifo_sat[wr_ptr + PTR_W'(n)]  <= push_sat[n];
`endif
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr     <= rd_ptr + PTR_W'(pop);
            fifo_count <= fifo_count + CNT_W'(push_cnt) - CNT_W'(pop);
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_row   = out_valid ? fifo_row[rd_ptr] : '0;
`ifdef SMVM_SAT_EN
    assign out_sat   = out_valid && fifo_sat[rd_ptr];
`else
    assign out_sat   = 1'b0;
`endif
    assign busy      = (state != IDLE) || s1_valid || out_valid;

endmodule

// File: tb/tb_smvm_kstream.sv
// tb_smvm_kstream: directed tests for smvm_kstream (ACC_W=16 so the
// saturation case is reachable). Build with +define+SMVM_SAT_EN to check
// the saturating variant.
module tb_smvm_kstream;
    localparam int K     = 4;
    localparam int VAL_W = 8;
    localparam int IDX_W = 9;
    localparam int ACC_W = 16;
    localparam int ROW_W = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [K-1:0]         in_lane_vld;
    logic [K*VAL_W-1:0]   in_val;
    logic [K*IDX_W-1:0]   in_idx;
    logic [K-1:0]         in_eor;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_data;
    logic [ROW_W-1:0]     out_row;
    logic                 out_sat;
    logic                 err_oob;
    logic                 busy;

    int vectors;
    int miscompares;
    bit drv_timeout;
    logic [VAL_W-1:0] vec_tb [16];

    smvm_kstream #(.K(K), .VAL_W(VAL_W), .IDX_W(IDX_W), .ACC_W(ACC_W),
                   .ROW_W(ROW_W), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_vld(in_lane_vld), .in_val(in_val), .in_idx(in_idx),
        .in_eor(in_eor), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_sat(out_sat),
        .err_oob(err_oob), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drive one beat and hold it until accepted (bounded)
    task automatic drive_beat(input logic [K-1:0] lv, input logic [K-1:0] eor, input logic last,
                              input logic [K*VAL_W-1:0] vals, input logic [K*IDX_W-1:0] idxs);
        int t;
        in_valid    = 1'b1;
        in_lane_vld = lv;
        in_eor      = eor;
        in_last     = last;
        in_val      = vals;
        in_idx      = idxs;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) drv_timeout = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_lane_vld = '0;
        in_eor      = '0;
        in_last     = 1'b0;
    endtask

    // CFG beat then ceil(cols/K) vector beats from vec_tb
    task automatic setup(input int cols);
        logic [K*VAL_W-1:0] v;
        drive_beat('0, '0, 1'b0, '0, {27'd0, 9'(cols - 1)});
        for (int b = 0; b < (cols + K - 1) / K; b++) begin
            v = '0;
            for (int j = 0; j < K; j++) v[j*VAL_W +: VAL_W] = vec_tb[b*K + j];
            drive_beat('0, '0, 1'b0, v, '0);
        end
    endtask

    // Wait (bounded) for a result and pop it
    task automatic collect(output logic [ACC_W-1:0] d, output logic [ROW_W-1:0] r,
                           output logic s, output bit ok);
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        ok = out_valid;
        d  = out_data;
        r  = out_row;
        s  = out_sat;
        if (ok) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int t;
        t = 0;
        while (busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_row !== '0 || out_sat !== 1'b0) begin
            $display("FAIL reset_out: got valid=%0b data=%0d row=%0d sat=%0b, want 0 0 0 0",
                     out_valid, out_data, out_row, out_sat);
            miscompares++;
        end
        vectors++;
        if (err_oob !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_ctl: got err_oob=%0b busy=%0b in_ready=%0b, want 0 0 1",
                     err_oob, busy, in_ready);
            miscompares++;
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic_rows();
        logic [ACC_W-1:0] d; logic [ROW_W-1:0] r; logic s; bit ok;
        vec_tb[0] = 8'd2; vec_tb[1] = 8'd3; vec_tb[2] = 8'd4;
        setup(3);
        // lanes: (5,c0,-) (1,c2,eor) (7,c1,eor), last
        drive_beat(4'b0111, 4'b0110, 1'b1, {8'd0, 8'd7, 8'd1, 8'd5}, {9'd0, 9'd1, 9'd2, 9'd0});
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL basic_lat1: got out_valid=%0b in_ready=%0b, want 0 0", out_valid, in_ready);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 16'd14 || out_row !== 16'd0) begin
            $display("FAIL basic_lat2: got valid=%0b data=%0d row=%0d, want 1 14 0",
                     out_valid, out_data, out_row);
            miscompares++;
        end
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== 16'd14 || r !== 16'd0) begin
            $display("FAIL basic_row0: got ok=%0b data=%0d row=%0d, want 14 row 0", ok, d, r);
            miscompares++;
        end
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== 16'd21 || r !== 16'd1) begin
            $display("FAIL basic_row1: got ok=%0b data=%0d row=%0d, want 21 row 1", ok, d, r);
            miscompares++;
        end
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            $display("FAIL basic_idle: got busy=%0b, want 0", busy);
            miscompares++;
        end
    endtask

    task automatic test_multi_beat();
        logic [ACC_W-1:0] d; logic [ROW_W-1:0] r; logic s; bit ok;
        vec_tb[0] = 8'd10;
        setup(1);
        drive_beat(4'b1111, 4'b0000, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, '0);
        drive_beat(4'b0001, 4'b0000, 1'b1, {24'd0, 8'd2}, '0);
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== 16'd60 || r !== 16'd0) begin
            $display("FAIL multi_row0: got ok=%0b data=%0d row=%0d, want 60 row 0", ok, d, r);
            miscompares++;
        end
        wait_idle(ok);
        vectors++;
        if (!ok || out_valid !== 1'b0) begin
            $display("FAIL multi_single: got busy=%0b out_valid=%0b, want 0 0", busy, out_valid);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        logic [ACC_W-1:0] d; logic [ROW_W-1:0] r; logic s; bit ok;
        int acc_cnt;
        vec_tb[0] = 8'd1;
        setup(1);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_lane_vld = 4'b1111;
        in_eor      = 4'b1111;
        in_last     = 1'b0;
        in_val      = {8'd1, 8'd1, 8'd1, 8'd1};
        in_idx      = '0;
        acc_cnt     = 0;
        for (int c = 0; c < 12; c++) begin
            if (in_ready) acc_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_lane_vld = '0;
        in_eor = '0;
        vectors++;
        if (acc_cnt !== 4 || in_ready !== 1'b0) begin
            $display("FAIL bp_stall: got accepted=%0d in_ready=%0b, want 4 0", acc_cnt, in_ready);
            miscompares++;
        end
        for (int i = 0; i < 16; i++) begin
            collect(d, r, s, ok);
            vectors++;
            if (!ok || d !== 16'd1 || r !== 16'(i)) begin
                $display("FAIL bp_row%0d: got ok=%0b data=%0d row=%0d, want 1 row %0d", i, ok, d, r, i);
                miscompares++;
            end
        end
        // empty closing beat: no open row, so nothing more is emitted
        drive_beat(4'b0000, 4'b0000, 1'b1, '0, '0);
        wait_idle(ok);
        vectors++;
        if (!ok || out_valid !== 1'b0) begin
            $display("FAIL bp_drain: got busy=%0b out_valid=%0b, want 0 0", busy, out_valid);
            miscompares++;
        end
    endtask

    task automatic test_oob();
        logic [ACC_W-1:0] d; logic [ROW_W-1:0] r; logic s; bit ok;
        vec_tb[0] = 8'd3; vec_tb[1] = 8'd4;
        setup(2);
        drive_beat(4'b0001, 4'b0001, 1'b1, {24'd0, 8'd9}, {27'd0, 9'd5});
        vectors++;
        if (err_oob !== 1'b1) begin
            $display("FAIL oob_flag: got err_oob=%0b, want 1", err_oob);
            miscompares++;
        end
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== 16'd0 || r !== 16'd0) begin
            $display("FAIL oob_row: got ok=%0b data=%0d row=%0d, want 0 row 0", ok, d, r);
            miscompares++;
        end
        wait_idle(ok);
        vectors++;
        if (!ok || err_oob !== 1'b1) begin
            $display("FAIL oob_sticky: got busy=%0b err_oob=%0b, want 0 1", busy, err_oob);
            miscompares++;
        end
        setup(2);
        vectors++;
        if (err_oob !== 1'b0) begin
            $display("FAIL oob_clear: got err_oob=%0b, want 0", err_oob);
            miscompares++;
        end
        drive_beat(4'b0000, 4'b0000, 1'b1, '0, '0);
        wait_idle(ok);
    endtask

    task automatic test_saturation();
        logic [ACC_W-1:0] d; logic [ROW_W-1:0] r; logic s; bit ok;
        logic [ACC_W-1:0] exp_d;
        logic exp_s;
`ifdef SMVM_SAT_EN
        exp_d = 16'd65535; exp_s = 1'b1;
`else
        exp_d = 16'd64514; exp_s = 1'b0;
`endif
        vec_tb[0] = 8'd255;
        setup(1);
        drive_beat(4'b0011, 4'b0010, 1'b1, {16'd0, 8'd255, 8'd255}, '0);
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== exp_d || s !== exp_s || r !== 16'd0) begin
            $display("FAIL sat_row: got ok=%0b data=%0d sat=%0b row=%0d, want %0d sat %0b row 0",
                     ok, d, s, r, exp_d, exp_s);
            miscompares++;
        end
        wait_idle(ok);
    endtask

    task automatic test_restart_while_draining();
        logic [ACC_W-1:0] d; logic [ROW_W-1:0] r; logic s; bit ok;
        vec_tb[0] = 8'd3;
        setup(1);
        drive_beat(4'b0001, 4'b0001, 1'b1, {24'd0, 8'd2}, '0);
        vec_tb[0] = 8'd5;
        setup(1);
        drive_beat(4'b0011, 4'b0011, 1'b1, {16'd0, 8'd2, 8'd1}, '0);
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== 16'd6 || r !== 16'd0) begin
            $display("FAIL restart_old: got ok=%0b data=%0d row=%0d, want 6 row 0", ok, d, r);
            miscompares++;
        end
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== 16'd5 || r !== 16'd0) begin
            $display("FAIL restart_new0: got ok=%0b data=%0d row=%0d, want 5 row 0", ok, d, r);
            miscompares++;
        end
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== 16'd10 || r !== 16'd1) begin
            $display("FAIL restart_new1: got ok=%0b data=%0d row=%0d, want 10 row 1", ok, d, r);
            miscompares++;
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid_mat();
        logic [ACC_W-1:0] d; logic [ROW_W-1:0] r; logic s; bit ok;
        vec_tb[0] = 8'd1;
        setup(1);
        drive_beat(4'b1111, 4'b1111, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, '0);
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            $display("FAIL rstmid_pre: got out_valid=%0b, want 1", out_valid);
            miscompares++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL rstmid_now: got out_valid=%0b busy=%0b in_ready=%0b, want 0 0 1",
                     out_valid, busy, in_ready);
            miscompares++;
        end
        @(posedge clk); #1 rst_n = 1'b1;
        vec_tb[0] = 8'd7;
        setup(1);
        drive_beat(4'b0001, 4'b0001, 1'b1, {24'd0, 8'd3}, '0);
        collect(d, r, s, ok);
        vectors++;
        if (!ok || d !== 16'd21 || r !== 16'd0) begin
            $display("FAIL rstmid_new: got ok=%0b data=%0d row=%0d, want 21 row 0", ok, d, r);
            miscompares++;
        end
        wait_idle(ok);
        vectors++;
        if (!ok || out_valid !== 1'b0) begin
            $display("FAIL rstmid_idle: got busy=%0b out_valid=%0b, want 0 0", busy, out_valid);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        drv_timeout = 1'b0;
        in_valid    = 1'b0;
        in_lane_vld = '0;
        in_val      = '0;
        in_idx      = '0;
        in_eor      = '0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        for (int i = 0; i < 16; i++) vec_tb[i] = '0;
        test_reset();
        do_reset();
        test_basic_rows();
        test_multi_beat();
        test_backpressure();
        test_oob();
        test_saturation();
        test_restart_while_draining();
        test_reset_mid_mat();
        vectors++;
        if (drv_timeout) begin
            $display("FAIL drive_timeout: got in_ready stuck low on a beat, want every beat accepted");
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/smvm_kstream.md
Name: smvm_kstream

Overview:
- K-lane streaming sparse-matrix × dense-vector engine.
- Loads a dense vector, then accepts up to K nonzeros per beat, each carrying a value, a column index and an end-of-row (EOR) flag.
- Multiplies each nonzero by its vector element, then reduces per row. A row may span any number of beats.
- Completed rows go through an output FIFO with ready/valid backpressure, replacing fixed-latency, non-backpressurable result delivery.

Parameters:
- K, 4: lanes per beat.
- VAL_W, 8: unsigned width of matrix and vector values.
- IDX_W, 9: column index width. Maximum columns = 2^IDX_W.
- ACC_W, 24: accumulator and result width.
- ROW_W, 16: row counter width.
- FIFO_DEPTH, 16: output FIFO entries. Must be at least 2*K and a power of 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  async reset, active low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_lane_vld  in  K  per-lane element valid (MAT phase)
- in_val  in  K*VAL_W  lane values; lane j occupies bits [j*VAL_W +: VAL_W]
- in_idx  in  K*IDX_W  lane column indices; in CFG, lane 0 carries cols-1
- in_eor  in  K  per-lane end-of-row flag
- in_last  in  1  final matrix beat
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  ACC_W  row sum
- out_row  out  ROW_W  row number, 0-based
- out_sat  out  1  row saturated (SMVM_SAT_EN only, else 0)
- err_oob  out  1  sticky: an index >= cols was seen since the last CFG
- busy  out  1  state != IDLE or pipeline/FIFO non-empty

Behaviour:
- Reset (async, rst_n low) does the following:
  - state = IDLE, FIFO emptied, accumulator cleared, row counter cleared, pipeline valids cleared.
  - Outputs: out_valid=0, out_data=0, out_row=0, out_sat=0, err_oob=0, busy=0, in_ready=1.
  - Vector RAM is not reset.
  - Reset mid-operation aborts the job; no partial row is emitted.
- States are IDLE, VEC, MAT and FLUSH.
  - IDLE: in_ready=1. An accepted beat is the CFG beat: latch cols = lane-0 in_idx + 1, clear err_oob, clear row counter → VEC.
  - VEC: in_ready=1. Beat b writes vec[b*K+j] = lane j in_val for every b*K+j < cols. After ceil(cols/K) beats → MAT.
  - MAT: in_ready = (FIFO free slots >= 2*K). An accepted beat with in_last → FLUSH.
  - FLUSH: in_ready=0. Waits until both pipeline stages are empty → IDLE. FIFO contents continue draining independently.
- Pipeline S1, registered one cycle after acceptance:
  - For each lane, prod_j = in_val_j * vec[in_idx_j], giving a 2*VAL_W product zero-extended to ACC_W.
  - If in_idx_j >= cols, prod_j = 0 and err_oob is set.
  - Invalid lanes contribute nothing and ignore in_eor.
- Pipeline S2, the segmented reduction:
  - Walk lanes 0 to K-1 in order: acc += prod_j.
  - On a valid lane with eor: push {acc, row}, row++, acc=0.
  - acc carries across beats.
  - On the in_last beat, after lane K-1: if a row is open (at least one element accumulated since the last EOR), push it as well.
  - Up to K pushes per cycle; the 2*K free-slot rule guarantees no overflow.
- Latency and ordering:
  - The first-word-fall-through FIFO gives out_valid 2 cycles after the beat containing the EOR is accepted, when the FIFO was empty.
  - Results leave in row order.
  - out_data, out_row and out_sat hold stable while out_valid && !out_ready.
- Arithmetic without the optional feature: acc wraps modulo 2^ACC_W.
- Boundaries:
  - A MAT beat with all lanes invalid is legal; with in_last it still flushes the open row.
  - Beats between acceptances may have in_valid=0.
  - Output backpressure never drops or reorders results.
  - A new CFG beat is accepted in IDLE while the FIFO is still draining; row numbering restarts at 0.

Optional Feature:
- Macro: SMVM_SAT_EN.
- Defined: each acc addition clamps to 2^ACC_W-1. The clamped row's FIFO entry carries sat=1, driven on out_sat.
- Undefined: acc wraps modulo 2^ACC_W, out_sat is tied to 0, and the FIFO has no sat bit.

Test Plan:
- Basic rows:
  - Stimulus: cols=3, vec=[2,3,4]. MAT beat lanes 0–2 = (5,c0,–), (1,c2,eor), (7,c1,eor), with in_last.
  - Response: out (14,row0), then (21,row1). busy returns to 0.
- Multi-beat row:
  - Stimulus: vec[0]=10. Beat 1: four lanes (1,c0), no eor. Beat 2: lane 0 (2,c0) with in_last and no eor.
  - Response: a single output (60,row0) via the implicit flush.
- Backpressure:
  - Stimulus: out_ready=0. Stream beats of 4 single-element rows (val 1, vec 1).
  - Response: in_ready falls once the FIFO holds more than 8 entries. Raising out_ready then yields rows 0..N in order, all =1, none lost.
- Out-of-bounds index:
  - Stimulus: cols=2, lane 0 (9,c5,eor).
  - Response: out 0, err_oob=1 until the next CFG beat.
- Saturation (ACC_W=16):
  - Stimulus: two lanes (255,c0) with vec[0]=255, eor on lane 1.
  - Response with SMVM_SAT_EN: out 65535, out_sat=1. Without it: out 64514, out_sat=0.
- Reset mid-MAT:
  - Stimulus: assert rst_n low between MAT beats.
  - Response: out_valid=0 immediately. After release, in_ready=1 in IDLE, and a new job produces correct results starting at row 0.
